// File: rtl/wave_framer.sv
// wave_framer: wraps FIFO sample bytes into frames for the Ethernet session.
// Frame layout: magic(2) seq(2) size(2) payload(size) [checksum(1)].
// Optional feature macro: WAVE_FRAMER_CSUM_EN adds a mod-256 payload checksum
// byte in TAIL; without it TAIL is a single silent cycle.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_trig                   async trigger level, rising edge starts a frame
//   i_size                   payload byte count, sampled at frame start
//   i_fifo_data/i_fifo_empty show-ahead FIFO, o_fifo_rd read strobe
//   i_full                   downstream backpressure
//   o_data/o_din/o_wr        framed byte, byte strobe, frame window
//   o_busy/o_seq/o_drop_cnt  status: not idle, last seq, dropped triggers
// SEQ_INIT sets the reset value of o_seq (0 in normal use).
module wave_framer #(
  parameter logic [15:0] HDR_MAGIC = 16'hA55A,
  parameter logic [15:0] MAX_SIZE  = 16'd8192,
  parameter logic [15:0] SEQ_INIT  = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_trig,
  input  logic [15:0] i_size,
  input  logic [7:0]  i_fifo_data,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd,
  input  logic        i_full,
  output logic [7:0]  o_data,
  output logic        o_din,
  output logic        o_wr,
  output logic        o_busy,
  output logic [15:0] o_seq,
  output logic [7:0]  o_drop_cnt
);

  localparam int unsigned HDR_LEN = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_TAIL,
    ST_DONE
  } state_t;

  state_t      state;
  logic        trig_s1, trig_s2, trig_s3;
  logic        rise;
  logic [2:0]  hdr_idx;
  logic [15:0] size_q;
  logic [15:0] pay_cnt;
  logic [15:0] size_clamp;
  logic [7:0]  hdr_byte;
  logic        emit_ok;
  logic        rd_ok;
`ifdef WAVE_FRAMER_CSUM_EN
  logic [7:0]  csum;
`endif

  // Edge detect on the synchronized trigger (s2 = current, s3 = previous).
  assign rise = trig_s2 & ~trig_s3;

  // Clamp to MAX_SIZE and force an even byte count.
  assign size_clamp = ((i_size > MAX_SIZE) ? MAX_SIZE : i_size) & 16'hFFFE;

  // A byte may leave only when the session can take it; reset kills output at once.
  assign emit_ok = ~i_rst & ~i_full;
  assign rd_ok   = (state == ST_DATA) & emit_ok & ~i_fifo_empty;

  // Header byte selector.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0:    hdr_byte = HDR_MAGIC[15:8];
      3'd1:    hdr_byte = HDR_MAGIC[7:0];
      3'd2:    hdr_byte = o_seq[15:8];
      3'd3:    hdr_byte = o_seq[7:0];
      3'd4:    hdr_byte = size_q[15:8];
      3'd5:    hdr_byte = size_q[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // Byte path is combinational so strobes track i_full/i_fifo_empty in the same cycle.
  always_comb begin
    o_din     = 1'b0;
    o_fifo_rd = 1'b0;
    o_data    = 8'h00;
    case (state)
      ST_HDR: begin
        o_din  = emit_ok;
        o_data = hdr_byte;
      end
      ST_DATA: begin
        o_fifo_rd = rd_ok;
        o_din     = rd_ok;
        o_data    = i_fifo_data;
      end
`ifdef WAVE_FRAMER_CSUM_EN
      ST_TAIL: begin
        o_din  = emit_ok;
        o_data = csum;
      end
`endif
      default: ;
    endcase
  end

  // Synchronizer, frame FSM and status registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      trig_s1    <= 1'b1;
      trig_s2    <= 1'b1;
      trig_s3    <= 1'b1;
      hdr_idx    <= 3'd0;
      size_q     <= 16'd0;
      pay_cnt    <= 16'd0;
      o_wr       <= 1'b0;
      o_busy     <= 1'b0;
      o_seq      <= SEQ_INIT;
      o_drop_cnt <= 8'd0;
`ifdef WAVE_FRAMER_CSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      trig_s1 <= i_trig;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;

      // Any rise outside IDLE is ignored and counted (saturating).
      if (rise && (state != ST_IDLE) && (o_drop_cnt != 8'hFF))
        o_drop_cnt <= 8'(o_drop_cnt + 8'd1);

      case (state)
        ST_IDLE: begin
          if (rise) begin
            state   <= ST_HDR;
            o_seq   <= 16'(o_seq + 16'd1);
            size_q  <= size_clamp;
            hdr_idx <= 3'd0;
            pay_cnt <= 16'd0;
            o_wr    <= 1'b1;
            o_busy  <= 1'b1;
`ifdef WAVE_FRAMER_CSUM_EN
            csum    <= 8'd0;
`endif
          end
        end
        ST_HDR: begin
          if (emit_ok) begin
            hdr_idx <= 3'(hdr_idx + 3'd1);
            if (hdr_idx == 3'(HDR_LEN - 1))
              state <= (size_q == 16'd0) ? ST_TAIL : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rd_ok) begin
            pay_cnt <= 16'(pay_cnt + 16'd1);
`ifdef WAVE_FRAMER_CSUM_EN
            csum    <= 8'(csum + i_fifo_data);
`endif
            if (16'(pay_cnt + 16'd1) == size_q)
              state <= ST_TAIL;
          end
        end
        ST_TAIL: begin
`ifdef WAVE_FRAMER_CSUM_EN
          if (emit_ok) begin
            state <= ST_DONE;
            o_wr  <= 1'b0;
          end
`else
          state <= ST_DONE;
          o_wr  <= 1'b0;
`endif
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_wr   <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_framer.sv
// Scoreboard bench for wave_framer: stimulus pushes expected bytes, a negedge
// monitor pops and compares on every o_din.
module tb_wave_framer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_trig = 1'b0;
  logic [15:0] i_size = 16'd0;
  logic [7:0]  i_fifo_data;
  logic        i_fifo_empty;
  logic        o_fifo_rd;
  logic        i_full = 1'b0;
  logic [7:0]  o_data;
  logic        o_din;
  logic        o_wr;
  logic        o_busy;
  logic [15:0] o_seq;
  logic [7:0]  o_drop_cnt;

  // Second instance reset near the sequence wrap point.
  logic        w_trig = 1'b0;
  logic [15:0] w_size = 16'd0;
  logic [7:0]  w_fifo_data = 8'd0;
  logic        w_fifo_empty = 1'b1;
  logic        w_full = 1'b0;
  logic        w_fifo_rd;
  logic [7:0]  w_data;
  logic        w_din;
  logic        w_wr;
  logic        w_busy;
  logic [15:0] w_seq;
  logic [7:0]  w_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  wave_framer u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_trig(i_trig), .i_size(i_size),
    .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty), .o_fifo_rd(o_fifo_rd),
    .i_full(i_full), .o_data(o_data), .o_din(o_din), .o_wr(o_wr),
    .o_busy(o_busy), .o_seq(o_seq), .o_drop_cnt(o_drop_cnt)
  );

  wave_framer #(.SEQ_INIT(16'hFFFE)) u_wrap (
    .i_clk(i_clk), .i_rst(i_rst), .i_trig(w_trig), .i_size(w_size),
    .i_fifo_data(w_fifo_data), .i_fifo_empty(w_fifo_empty), .o_fifo_rd(w_fifo_rd),
    .i_full(w_full), .o_data(w_data), .o_din(w_din), .o_wr(w_wr),
    .o_busy(w_busy), .o_seq(w_seq), .o_drop_cnt(w_drop_cnt)
  );

  // Show-ahead FIFO model.
  logic [7:0] fifo_mem [0:255];
  int wptr = 0;
  int rptr = 0;
  assign i_fifo_empty = (rptr == wptr);
  assign i_fifo_data  = fifo_mem[8'(rptr)];
  always @(posedge i_clk) if (o_fifo_rd && !i_fifo_empty) rptr <= rptr + 1;

  // Scoreboard and monitor counters.
  logic [7:0] exp_q [$];
  int din_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int w_din_cnt = 0;
  logic [7:0] mon_exp;

  always @(negedge i_clk) begin
    if (o_busy && !o_wr) done_cnt++;
    if (w_din) w_din_cnt++;
    if (o_fifo_rd) begin
      rd_cnt++;
      if (i_full || i_fifo_empty) begin
        errors++;
        $display("FAIL fifo_rd_guard: rd=1 full=%0b empty=%0b, required rd=0", i_full, i_fifo_empty);
      end
    end
    if (o_din) begin
      din_cnt++;
      if (i_full) begin
        errors++;
        $display("FAIL din_while_full: din=1 with full=1, required din=0");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %02h, no byte expected", o_data);
      end else begin
        mon_exp = exp_q.pop_front();
        checks++;
        if (o_data !== mon_exp) begin
          errors++;
          $display("FAIL byte: got %02h required %02h", o_data, mon_exp);
        end
      end
    end
  end

  // Stimulus-side model state.
  int exp_rptr = 0;
  logic [15:0] exp_seq = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fifo_mem[8'(wptr)] = b;
    wptr++;
  endtask

  task automatic exp_hdr(input logic [15:0] sz);
    exp_seq = exp_seq + 16'd1;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(exp_seq[15:8]);
    exp_q.push_back(exp_seq[7:0]);
    exp_q.push_back(sz[15:8]);
    exp_q.push_back(sz[7:0]);
  endtask

  task automatic exp_frame(input logic [15:0] size_in);
    logic [15:0] sz;
    logic [7:0] sum;
    sz = (size_in > 16'd8192) ? 16'd8192 : size_in;
    sz[0] = 1'b0;
    exp_hdr(sz);
    sum = 8'd0;
    for (int i = 0; i < int'(sz); i++) begin
      exp_q.push_back(fifo_mem[8'(exp_rptr + i)]);
      sum = 8'(sum + fifo_mem[8'(exp_rptr + i)]);
    end
    exp_rptr += int'(sz);
`ifdef WAVE_FRAMER_CSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic pulse_trig();
    step();
    i_trig = 1'b1;
    step();
    i_trig = 1'b0;
  endtask

  task automatic wait_frame(input bit alt, input string name);
    int n = 0;
    while (!o_busy && n < 20) begin step(); n++; end
    while ((o_busy || exp_q.size() != 0) && n < 2000) begin
      step();
      if (alt) i_full = ~i_full;
      n++;
    end
    i_full = 1'b0;
    checks++;
    if (n >= 2000 || o_busy) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b left=%0d, required frame end", name, o_busy, exp_q.size());
    end
  endtask

  task automatic wait_din(input int target, input string name);
    int n = 0;
    while (din_cnt < target && n < 200) begin step(); n++; end
    checks++;
    if (din_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: din_cnt=%0d required %0d", name, din_cnt, target);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_wr"}, 32'(o_wr), 32'd0);
    check({name, "_din"}, 32'(o_din), 32'd0);
    check({name, "_rd"}, 32'(o_fifo_rd), 32'd0);
    check({name, "_data"}, 32'(o_data), 32'd0);
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    check({name, "_seq"}, 32'(o_seq), 32'd0);
    check({name, "_drop"}, 32'(o_drop_cnt), 32'd0);
  endtask

  initial begin
    int rd0, done0, din0, wd0, n;

    // Reset with trigger already high: no frame after release.
    i_trig = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_vals("rst");
    step();
    i_rst = 1'b0;
    repeat (8) step();
    check("trig_high_at_release_busy", 32'(o_busy), 32'd0);
    check("trig_high_at_release_din", 32'(din_cnt), 32'd0);
    i_trig = 1'b0;
    repeat (3) step();

    // Basic frame, size 8, payload 00..07, with first-byte latency check.
    for (int i = 0; i < 8; i++) fifo_push(8'(i));
    i_size = 16'd8;
    exp_frame(16'd8);
    rd0 = rd_cnt; done0 = done_cnt;
    step();
    i_trig = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("latency_edge2_din", 32'(o_din), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("latency_edge3_din", 32'(o_din), 32'd1);
    check("latency_edge3_data", 32'(o_data), 32'hA5);
    check("latency_edge3_wr", 32'(o_wr), 32'd1);
    i_trig = 1'b0;
    wait_frame(1'b0, "basic");
    check("basic_seq", 32'(o_seq), 32'd1);
    check("basic_reads", 32'(rd_cnt - rd0), 32'd8);
    check("basic_done_cycles", 32'(done_cnt - done0), 32'd1);

    // Same frame shape under alternating backpressure.
    for (int i = 0; i < 8; i++) fifo_push(8'(8'h10 + i));
    exp_frame(16'd8);
    rd0 = rd_cnt;
    pulse_trig();
    wait_frame(1'b1, "altfull");
    check("altfull_seq", 32'(o_seq), 32'd2);
    check("altfull_reads", 32'(rd_cnt - rd0), 32'd8);

    // Zero-size frame: header only, no FIFO reads.
    i_size = 16'd0;
    exp_frame(16'd0);
    rd0 = rd_cnt;
    pulse_trig();
    wait_frame(1'b0, "size0");
    check("size0_reads", 32'(rd_cnt - rd0), 32'd0);
    check("size0_seq", 32'(o_seq), 32'd3);

    // Odd size rounds down: 9 -> 8 reads, one byte left in the FIFO.
    for (int i = 0; i < 9; i++) fifo_push(8'(8'h20 + i));
    i_size = 16'd9;
    exp_frame(16'd9);
    rd0 = rd_cnt;
    pulse_trig();
    wait_frame(1'b0, "size9");
    check("size9_reads", 32'(rd_cnt - rd0), 32'd8);
    check("size9_fifo_left", 32'(wptr - rptr), 32'd1);

    // Three triggers during a stalled DATA phase are dropped.
    i_size = 16'd8;
    for (int i = 0; i < 7; i++) fifo_mem[8'(wptr + i)] = 8'(8'h30 + i);
    exp_frame(16'd8);
    done0 = done_cnt;
    din0 = din_cnt;
    pulse_trig();
    wait_din(din0 + 7, "drop_enter_data");
    repeat (3) pulse_trig();
    repeat (4) step();
    check("drop_still_busy", 32'(o_busy), 32'd1);
    wptr += 7;
    wait_frame(1'b0, "drop");
    repeat (10) step();
    check("drop_cnt", 32'(o_drop_cnt), 32'd3);
    check("drop_single_frame", 32'(done_cnt - done0), 32'd1);
    check("drop_seq", 32'(o_seq), 32'd5);
    check("drop_idle_after", 32'(o_busy), 32'd0);

    // Oversize request clamps to 8192; abort with reset once the header is out.
    i_size = 16'hFFFF;
    exp_hdr(16'h2000);
    din0 = din_cnt;
    rd0 = rd_cnt;
    pulse_trig();
    wait_din(din0 + 6, "clamp_hdr");
    repeat (3) step();
    check("clamp_hdr_consumed", 32'(exp_q.size()), 32'd0);
    check("clamp_waiting_busy", 32'(o_busy), 32'd1);
    check("clamp_no_reads", 32'(rd_cnt - rd0), 32'd0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    exp_seq = 16'd0;
    check("clamp_rst_seq", 32'(o_seq), 32'd0);

    // Reset in DATA after 4 payload bytes, then a clean frame with seq 1.
    for (int i = 0; i < 8; i++) fifo_push(8'(8'h40 + i));
    i_size = 16'd8;
    exp_frame(16'd8);
    rd0 = rd_cnt;
    pulse_trig();
    n = 0;
    while ((rd_cnt - rd0) < 4 && n < 200) begin step(); n++; end
    check("midrst_reads_before", 32'(rd_cnt - rd0), 32'd4);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check_reset_vals("midrst");
    check("midrst_reads_total", 32'(rd_cnt - rd0), 32'd4);
    step();
    i_rst = 1'b0;
    exp_q.delete();
    exp_rptr = exp_rptr - 4;
    exp_seq = 16'd0;
    i_size = 16'd4;
    exp_frame(16'd4);
    pulse_trig();
    wait_frame(1'b0, "post_rst");
    check("post_rst_seq", 32'(o_seq), 32'd1);
    check("post_rst_drop", 32'(o_drop_cnt), 32'd0);
    check("post_rst_fifo_empty", 32'(i_fifo_empty), 32'd1);

    // Sequence wrap on the second instance: FFFF then 0000.
    for (int f = 0; f < 2; f++) begin
      wd0 = w_din_cnt;
      step();
      w_trig = 1'b1;
      step();
      w_trig = 1'b0;
      n = 0;
      while (!w_busy && n < 20) begin step(); n++; end
      while (w_busy && n < 200) begin step(); n++; end
      check("wrap_idle", 32'(w_busy), 32'd0);
`ifdef WAVE_FRAMER_CSUM_EN
      check("wrap_bytes", 32'(w_din_cnt - wd0), 32'd7);
`else
      check("wrap_bytes", 32'(w_din_cnt - wd0), 32'd6);
`endif
      check("wrap_seq", 32'(w_seq), (f == 0) ? 32'h0000FFFF : 32'h00000000);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
